// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: owns IF (0xFF0F) and IE (0xFFFF) and serves the CPU dispatch handshake.
// GB_INT_CANCEL_EN picks the vector at disp_sel (DMG cancel behaviour); otherwise the winner is latched at disp_start.
module gb_int_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  irq_src,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  input  logic        ime,
  output logic        int_pending,
  output logic        int_req,
  input  logic        disp_start,
  input  logic        disp_sel,
  output logic [7:0]  vec,
  output logic        vec_valid
);

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [2:0] IDX_NONE = 3'd5;

  // Lowest set bit wins; IDX_NONE when nothing is pending.
  function automatic logic [2:0] lowest_idx(input logic [4:0] m);
    logic [2:0] idx;
    casez (m)
      5'b????1: idx = 3'd0;
      5'b???10: idx = 3'd1;
      5'b??100: idx = 3'd2;
      5'b?1000: idx = 3'd3;
      5'b10000: idx = 3'd4;
      default:  idx = IDX_NONE;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'h40;
      3'd1:    v = 8'h48;
      3'd2:    v = 8'h50;
      3'd3:    v = 8'h58;
      3'd4:    v = 8'h60;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t      state_r;
  logic [4:0]  if_r;
  logic [7:0]  ie_r;
  logic [7:0]  vec_r;
  logic        vec_valid_r;
  logic        sel_if_s;
  logic        sel_ie_s;
  logic        if_wr_s;
  logic        ie_wr_s;
  logic [4:0]  active_s;
  logic [2:0]  cur_idx_s;
  logic [2:0]  disp_idx_s;
  logic        disp_fire_s;
  logic [4:0]  clr_mask_s;
  logic [4:0]  if_next_s;
  logic [7:0]  rdata_s;
`ifndef GB_INT_CANCEL_EN
  logic [2:0]  idx_r;
`endif

  assign sel_if_s    = (bus_addr == 16'hFF0F);
  assign sel_ie_s    = (bus_addr == 16'hFFFF);
  assign bus_hit     = (sel_if_s || sel_ie_s) && (bus_re || bus_we);
  assign if_wr_s     = bus_we && sel_if_s;
  assign ie_wr_s     = bus_we && sel_ie_s;
  assign active_s    = ie_r[4:0] & if_r;
  assign cur_idx_s   = lowest_idx(active_s);
  assign disp_fire_s = (state_r == ARMED) && disp_sel;

`ifdef GB_INT_CANCEL_EN
  assign disp_idx_s = cur_idx_s;
`else
  assign disp_idx_s = idx_r;
`endif

  // Dispatch clear mask for the bit being acknowledged this cycle
  always_comb begin
    clr_mask_s = 5'd0;
    if (disp_fire_s && (disp_idx_s < IDX_NONE)) begin
      clr_mask_s = 5'd1 << disp_idx_s;
    end else begin
      clr_mask_s = 5'd0;
    end
  end

  // Write base, then dispatch clear, then sources; a set always wins
  always_comb begin
    if_next_s = if_r;
    if (if_wr_s) begin
      if_next_s = bus_wdata[4:0];
    end else begin
      if_next_s = if_r;
    end
    if_next_s = (if_next_s & ~clr_mask_s) | irq_src;
  end

  // Combinational read mux returning pre-write contents
  always_comb begin
    rdata_s = 8'h00;
    if (bus_hit && sel_if_s) begin
      rdata_s = {3'b111, if_r};
    end else if (bus_hit && sel_ie_s) begin
      rdata_s = ie_r;
    end else begin
      rdata_s = 8'h00;
    end
  end

  // IF / IE register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      if_r <= 5'd0;
      ie_r <= 8'd0;
    end else begin
      if_r <= if_next_s;
      if (ie_wr_s) begin
        ie_r <= bus_wdata;
      end else begin
        ie_r <= ie_r;
      end
    end
  end

  // Dispatch FSM with registered vector outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      vec_r       <= 8'h00;
      vec_valid_r <= 1'b0;
`ifndef GB_INT_CANCEL_EN
      idx_r       <= IDX_NONE;
`endif
    end else begin
      vec_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (disp_start) begin
            state_r <= ARMED;
`ifndef GB_INT_CANCEL_EN
            idx_r   <= cur_idx_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          if (disp_sel) begin
            state_r     <= IDLE;
            vec_r       <= vec_of(disp_idx_s);
            vec_valid_r <= 1'b1;
          end else begin
            state_r <= ARMED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus_rdata   = rdata_s;
  assign int_pending = (active_s != 5'd0);
  assign int_req     = int_pending && ime && (state_r == IDLE);
  assign vec         = vec_r;
  assign vec_valid   = vec_valid_r;

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Self-checking bench for gb_int_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_gb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  irq_src;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic        bus_hit;
  logic        ime;
  logic        int_pending;
  logic        int_req;
  logic        disp_start;
  logic        disp_sel;
  logic [7:0]  vec;
  logic        vec_valid;

  int n_cmp;
  int n_fail;

  // Behavioural model state
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_armed;
  int         m_lidx;
  logic [7:0] m_vec;
  logic       m_vv;

  gb_int_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_hit(bus_hit), .ime(ime),
    .int_pending(int_pending), .int_req(int_req), .disp_start(disp_start),
    .disp_sel(disp_sel), .vec(vec), .vec_valid(vec_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input logic [4:0] m);
    for (int i = 0; i < 5; i++) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one edge from the inputs now driven, then clock the DUT.
  task automatic tick();
    logic [4:0] nif;
    logic       wif;
    logic       wie;
    logic       fire;
    int         idx;
    if (reset) begin
      m_if = 5'd0; m_ie = 8'd0; m_armed = 1'b0; m_lidx = -1; m_vec = 8'h00; m_vv = 1'b0;
    end else begin
      wif  = bus_we && (bus_addr == 16'hFF0F);
      wie  = bus_we && (bus_addr == 16'hFFFF);
      fire = m_armed && disp_sel;
      nif  = wif ? bus_wdata[4:0] : m_if;
      m_vv = fire;
      if (fire) begin
`ifdef GB_INT_CANCEL_EN
        idx = lowest(m_ie[4:0] & m_if);
`else
        idx = m_lidx;
`endif
        if (idx >= 0) begin
          nif[idx] = 1'b0;
          m_vec = 8'h40 + 8'(idx * 8);
        end else begin
          m_vec = 8'h00;
        end
      end
      nif = nif | irq_src;
      if (!m_armed && disp_start) begin
        m_armed = 1'b1;
        m_lidx  = lowest(m_ie[4:0] & m_if);
      end else if (fire) begin
        m_armed = 1'b0;
      end
      if (wie) m_ie = bus_wdata;
      m_if = nif;
    end
    @(posedge clk);
    #1;
    bus_we = 1'b0; bus_re = 1'b0; disp_start = 1'b0; disp_sel = 1'b0; irq_src = 5'd0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic h);
    bus_addr = a; bus_re = 1'b1;
    #1;
    d = bus_rdata; h = bus_hit;
    bus_re = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic h;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus_addr = 16'hFF0F; #1;
    n_cmp++; if (bus_hit !== 1'b0 || bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_idle_bus: got hit=%b rdata=%h expected 0/00", bus_hit, bus_rdata); end
    n_cmp++; if (int_pending !== 1'b0 || int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int: got pend=%b req=%b expected 0/0", int_pending, int_req); end
    n_cmp++; if (vec_valid !== 1'b0 || vec !== 8'h00) begin n_fail++; $display("FAIL reset_vec: got vv=%b vec=%h expected 0/00", vec_valid, vec); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE0 || h !== 1'b1) begin n_fail++; $display("FAIL reset_if: got %h hit=%b expected e0 hit=1", d, h); end
    rd(16'hFFFF, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ie: got %h expected 00", d); end
  endtask

  task automatic test_latch();
    logic [7:0] d; logic h;
    ime = 1'b0;
    wr(16'hFFFF, 8'h05);
    irq_src = 5'b00100;
    tick();
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE4) begin n_fail++; $display("FAIL latch_if: got %h expected e4", d); end
    n_cmp++; if (int_pending !== 1'b1 || int_req !== 1'b0) begin n_fail++; $display("FAIL latch_pend_ime0: got pend=%b req=%b expected 1/0", int_pending, int_req); end
    ime = 1'b1; #1;
    n_cmp++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL latch_req_ime1: got %b expected 1", int_req); end
  endtask

  task automatic test_dispatch();
    logic [7:0] d; logic h;
    wr(16'hFF0F, 8'h1F);
    wr(16'hFFFF, 8'h1F);
    ime = 1'b1;
    disp_start = 1'b1; tick();
    n_cmp++; if (int_req !== 1'b0 || int_pending !== 1'b1) begin n_fail++; $display("FAIL disp_armed_req: got req=%b pend=%b expected 0/1", int_req, int_pending); end
    tick();
    disp_sel = 1'b1; tick();
    n_cmp++; if (vec_valid !== 1'b1 || vec !== 8'h40) begin n_fail++; $display("FAIL disp1_vec: got vv=%b vec=%h expected 1/40", vec_valid, vec); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hFE) begin n_fail++; $display("FAIL disp1_if: got %h expected fe", d); end
    tick();
    n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL disp1_pulse: got vv=%b expected 0", vec_valid); end
    disp_start = 1'b1; tick();
    disp_sel = 1'b1; tick();
    n_cmp++; if (vec_valid !== 1'b1 || vec !== 8'h48) begin n_fail++; $display("FAIL disp2_vec: got vv=%b vec=%h expected 1/48", vec_valid, vec); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hFC) begin n_fail++; $display("FAIL disp2_if: got %h expected fc", d); end
  endtask

  task automatic test_set_dominates();
    logic [7:0] d; logic h;
    bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_we = 1'b1; irq_src = 5'b00001;
    tick();
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE1) begin n_fail++; $display("FAIL set_vs_write: got %h expected e1", d); end
    wr(16'hFF0F, 8'h04);
    wr(16'hFFFF, 8'h04);
    disp_start = 1'b1; tick();
    disp_sel = 1'b1; irq_src = 5'b00100; tick();
    n_cmp++; if (vec_valid !== 1'b1 || vec !== 8'h50) begin n_fail++; $display("FAIL set_vs_clr_vec: got vv=%b vec=%h expected 1/50", vec_valid, vec); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE4) begin n_fail++; $display("FAIL set_vs_clr_if: got %h expected e4", d); end
  endtask

  task automatic test_cancel();
    logic [7:0] d; logic h;
    wr(16'hFF0F, 8'h04);
    wr(16'hFFFF, 8'h04);
    disp_start = 1'b1; tick();
    wr(16'hFFFF, 8'h00);
    disp_sel = 1'b1; tick();
    rd(16'hFF0F, d, h);
`ifdef GB_INT_CANCEL_EN
    n_cmp++; if (vec_valid !== 1'b1 || vec !== 8'h00) begin n_fail++; $display("FAIL cancel_vec: got vv=%b vec=%h expected 1/00", vec_valid, vec); end
    n_cmp++; if (d !== 8'hE4) begin n_fail++; $display("FAIL cancel_if: got %h expected e4", d); end
`else
    n_cmp++; if (vec_valid !== 1'b1 || vec !== 8'h50) begin n_fail++; $display("FAIL latched_vec: got vv=%b vec=%h expected 1/50", vec_valid, vec); end
    n_cmp++; if (d !== 8'hE0) begin n_fail++; $display("FAIL latched_if: got %h expected e0", d); end
`endif
  endtask

  task automatic test_reset_armed();
    logic [7:0] d; logic h;
    wr(16'hFF0F, 8'h04);
    wr(16'hFFFF, 8'h04);
    disp_start = 1'b1; tick();
    reset = 1'b1; disp_sel = 1'b1; tick();
    reset = 1'b0;
    n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_armed_vv: got %b expected 0", vec_valid); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE0) begin n_fail++; $display("FAIL rst_armed_if: got %h expected e0", d); end
    wr(16'hFF0F, 8'h01);
    wr(16'hFFFF, 8'h01);
    n_cmp++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL rst_armed_idle_req: got %b expected 1", int_req); end
    for (int i = 0; i < 3; i++) begin
      disp_sel = 1'b1; tick();
      n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_armed_sel%0d: got vv=%b expected 0", i, vec_valid); end
    end
  endtask

  task automatic test_stray_and_decode();
    logic [7:0] d; logic h;
    wr(16'hFF0F, 8'h03);
    wr(16'hFFFF, 8'h03);
    disp_sel = 1'b1; tick();
    n_cmp++; if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL stray_sel_vv: got %b expected 0", vec_valid); end
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE3) begin n_fail++; $display("FAIL stray_sel_if: got %h expected e3", d); end
    bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_we = 1'b1; bus_re = 1'b1; #1;
    n_cmp++; if (bus_rdata !== 8'hE3 || bus_hit !== 1'b1) begin n_fail++; $display("FAIL rd_during_wr: got %h hit=%b expected e3 hit=1", bus_rdata, bus_hit); end
    tick();
    rd(16'hFF0F, d, h);
    n_cmp++; if (d !== 8'hE0) begin n_fail++; $display("FAIL after_wr_if: got %h expected e0", d); end
    rd(16'hFF0E, d, h);
    n_cmp++; if (h !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL decode_ff0e: got hit=%b rdata=%h expected 0/00", h, d); end
    rd(16'hFF10, d, h);
    n_cmp++; if (h !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL decode_ff10: got hit=%b rdata=%h expected 0/00", h, d); end
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    logic       exp_hit;
    logic       exp_pend;
    for (int it = 0; it < 600; it++) begin
      reset      = ($urandom_range(0, 99) < 2);
      irq_src    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      case ($urandom_range(0, 3))
        0:       bus_addr = 16'hFF0F;
        1:       bus_addr = 16'hFFFF;
        2:       bus_addr = ($urandom_range(0, 1) == 0) ? 16'hFF0E : 16'hFF10;
        default: bus_addr = 16'($urandom);
      endcase
      bus_wdata  = 8'($urandom);
      bus_we     = ($urandom_range(0, 4) == 0);
      bus_re     = ($urandom_range(0, 1) == 0);
      ime        = ($urandom_range(0, 3) != 0);
      disp_start = ($urandom_range(0, 5) == 0);
      disp_sel   = ($urandom_range(0, 4) == 0);
      #1;
      exp_hit  = ((bus_addr == 16'hFF0F) || (bus_addr == 16'hFFFF)) && (bus_re || bus_we);
      exp_rd   = !exp_hit ? 8'h00 : (bus_addr == 16'hFF0F) ? {3'b111, m_if} : m_ie;
      exp_pend = ((m_ie[4:0] & m_if) != 5'd0);
      n_cmp++; if (bus_hit !== exp_hit || bus_rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_bus[%0d]: got hit=%b rdata=%h expected %b/%h", it, bus_hit, bus_rdata, exp_hit, exp_rd); end
      n_cmp++; if (int_pending !== exp_pend) begin n_fail++; $display("FAIL rnd_pend[%0d]: got %b expected %b", it, int_pending, exp_pend); end
      n_cmp++; if (int_req !== (exp_pend && ime && !m_armed)) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b expected %b", it, int_req, exp_pend && ime && !m_armed); end
      n_cmp++; if (vec_valid !== m_vv) begin n_fail++; $display("FAIL rnd_vv[%0d]: got %b expected %b", it, vec_valid, m_vv); end
      if (m_vv) begin
        n_cmp++; if (vec !== m_vec) begin n_fail++; $display("FAIL rnd_vec[%0d]: got %h expected %h", it, vec, m_vec); end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; irq_src = 5'd0; bus_addr = 16'h0000; bus_wdata = 8'h00;
    bus_we = 1'b0; bus_re = 1'b0; ime = 1'b0; disp_start = 1'b0; disp_sel = 1'b0;
    m_if = 5'd0; m_ie = 8'd0; m_armed = 1'b0; m_lidx = -1; m_vec = 8'h00; m_vv = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_latch();
    test_dispatch();
    test_set_dominates();
    test_cancel();
    test_reset_armed();
    test_stray_and_decode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_int_ctrl.md
# gb_int_ctrl

Game Boy interrupt controller: the responder side of the CPU's interrupt interface. It owns the IF (0xFF0F) and IE (0xFFFF) registers and latches request pulses from the PPU, timer, serial and joypad blocks. It tells the CPU when an interrupt is pending and, during the CPU's dispatch sequence, picks the highest-priority source, clears it and returns its vector. The CPU core keeps IME; this block only samples it.

## Interface
- No parameters.
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high.
- irq_src  in  5  one-cycle request pulses. Bit 0 VBlank, bit 1 STAT, bit 2 Timer, bit 3 Serial, bit 4 Joypad.
- bus_addr  in  16  CPU bus address.
- bus_wdata  in  8  write data.
- bus_we  in  1  write strobe; one cycle per access.
- bus_re  in  1  read strobe.
- bus_rdata  out  8  read data; combinational; 0x00 when `bus_hit` is low.
- bus_hit  out  1  `bus_addr` is 0xFF0F or 0xFFFF, and `bus_re` or `bus_we` is high.
- ime  in  1  CPU interrupt master enable.
- int_pending  out  1  (IE & IF[4:0]) != 0, regardless of IME. Used for HALT/STOP wake.
- int_req  out  1  `int_pending && ime && state==IDLE`.
- disp_start  in  1  pulse; CPU has begun the interrupt dispatch M-cycles.
- disp_sel  in  1  pulse; CPU needs the vector (the PC-low push cycle).
- vec  out  8  dispatch vector; registered; valid while `vec_valid` is high.
- vec_valid  out  1  one-cycle pulse, the cycle after the accepted `disp_sel`.

## Operation
- Registers: IF[4:0] and IE[7:0].
  - IF reads as {3'b111, IF[4:0]}.
  - IE reads and writes all 8 bits, but only IE[4:0] take part in priority.
- IF next value, applied in this order:
  1. Base value: `bus_wdata[4:0]` if IF is written this cycle, else the current IF.
  2. Dispatch clear: AND with the inverted dispatch-clear mask.
  3. Sources: OR with `irq_src`. Set always dominates, whether the competing event is a write or a dispatch clear.
- IE updates only on a bus write.
- Priority: lowest set bit of (IE & IF[4:0]) wins.
- Vectors: bit 0 → 0x40, bit 1 → 0x48, bit 2 → 0x50, bit 3 → 0x58, bit 4 → 0x60. Nothing selected → 0x00.
- State machine: IDLE, ARMED.
  - IDLE --`disp_start`--> ARMED. Only accepted in IDLE.
  - ARMED --`disp_sel`--> IDLE. In the same edge: clear the chosen IF bit, register `vec`, and assert `vec_valid` the next cycle.
  - `disp_sel` in IDLE is ignored: no clear, no `vec_valid`.
  - `disp_start` in ARMED is ignored.
  - `disp_start` and `disp_sel` in the same cycle in IDLE: the block enters ARMED only; `disp_sel` is ignored.
- IME is not checked during ARMED. The CPU has already committed.

## Timing
- Reset values:
  - IF = 0x00, IE = 0x00, state = IDLE.
  - `vec` = 0x00, `vec_valid` = 0, `int_pending` = 0, `int_req` = 0.
  - `bus_rdata` = 0x00 and `bus_hit` = 0 unless an access is present.
- Reset in ARMED returns to IDLE. No IF bit is cleared and `vec_valid` stays low.
- Latency:
  - `irq_src` pulse at edge N sets IF at N. `int_pending` / `int_req` are high from cycle N+1.
  - A bus write to IE/IF is visible on `int_pending` the cycle after the write.
  - `disp_sel` at edge N gives `vec` / `vec_valid` during cycle N+1. The cleared IF bit is visible on reads from cycle N+1.
- Reads are combinational and same-cycle. A read in the same cycle as a write returns the pre-write value.

## Configuration
- `GB_INT_CANCEL_EN` defined (the default build): the vector is chosen at `disp_sel` from the IE & IF values of that cycle.
  - If IE was rewritten during the push so nothing remains, `vec` = 0x00 and no bit is cleared. This models the DMG dispatch-cancel behaviour.
  - A higher-priority source that arrives between `disp_start` and `disp_sel` wins.
- Undefined: the winning index is latched into a 3-bit register at `disp_start`.
  - At `disp_sel` that bit is cleared and its vector is returned, whatever IE/IF now hold.
  - If nothing was pending at `disp_start`, the result is `vec` = 0x00 with no clear.

## Test plan
- Reset, write IE=0x05, pulse `irq_src`=5'b00100 → IF reads 0xE4. `int_pending`=1 the next cycle. `int_req` follows `ime`.
- Set IF=0x1F via the bus, IE=0x1F, `ime`=1. `disp_start`, then `disp_sel` two cycles later → `vec`=0x40 with a one-cycle `vec_valid`, IF reads 0xFE. A second dispatch → `vec`=0x48, IF reads 0xFC.
- Simultaneous bus write IF=0x00 and `irq_src`=5'b00001 → IF reads 0xE1. Simultaneous dispatch clear of bit 2 and `irq_src` bit 2 → bit 2 remains set.
- Cancel with `GB_INT_CANCEL_EN`: IE=IF=0x04, `disp_start`, write IE=0x00, `disp_sel` → `vec`=0x00, IF still reads 0xE4. Without the macro, the same sequence gives `vec`=0x50 and IF reads 0xE0.
- Reset asserted in ARMED → state IDLE, `vec_valid` never pulses, IF unchanged from before reset except for the reset clear to 0x00.
- `disp_sel` with no preceding `disp_start` → no `vec_valid`, IF unchanged. Reads of 0xFF0E and 0xFF10 → `bus_hit`=0, `bus_rdata`=0x00.
